bp_mac_array: RTL and testbench

Parametrised multi-lane, two-stage pipelined signed MAC for the PE datapath; the successor to the single-lane registered MAC-with-saturation. Each lane computes `a*w + addend`. The addend is either an external partial sum (CHAIN mode, FIR/systolic chaining) or the lane's own running accumulator (ACCUM mode, dot-product over `acc_len` beats). Valid/ready handshakes are on both sides. It sits between the PE operand fetch and the partial-sum writeback.

---
 rtl/mac_pkg.sv | 20 ++
 rtl/mac_lane_sat.sv | 52 +++++
 rtl/bp_mac_array.sv | 202 ++++++++++++++++++++
 tb/tb_bp_mac_array.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// Shared definitions for the bp_mac_array multi-lane MAC: mode encoding,
// group FSM states and the internal sum width helper.
package mac_pkg;

   localparam logic MAC_MODE_CHAIN = 1'b0;
   localparam logic MAC_MODE_ACCUM = 1'b1;

   typedef enum logic {
      IDLE = 1'b0,
      ACC  = 1'b1
   } grp_state_t;

   // Width that holds product + addend without loss: one bit above the wider operand.
   function automatic int sum_width(input int a_w, input int w_w, input int acc_w);
      int p_w;
      p_w = a_w + w_w;
      return ((p_w > acc_w) ? p_w : acc_w) + 1;
   endfunction

endpackage

// File: rtl/mac_lane_sat.sv
// One MAC lane adder: sign-extended product + addend reduced to ACC_W bits.
// Build option MAC_SAT_EN: clamp to the signed ACC_W range and flag ovf on clamp;
// without it the sum wraps two's-complement and ovf stays 0.
module mac_lane_sat
   import mac_pkg::*;
#(
   parameter int A_W   = 16,
   parameter int W_W   = 16,
   parameter int ACC_W = 24
) (
   input  logic signed [A_W+W_W-1:0] p,
   input  logic signed [ACC_W-1:0]   addend,
   output logic signed [ACC_W-1:0]   y,
   output logic                      ovf
);

   localparam int P_W   = A_W + W_W;
   localparam int SUM_W = sum_width(A_W, W_W, ACC_W);

   logic signed [SUM_W-1:0] sum_s;

   // Full-precision sum of both operands at the common width.
   always_comb begin
      sum_s = {{(SUM_W-P_W){p[P_W-1]}}, p} + {{(SUM_W-ACC_W){addend[ACC_W-1]}}, addend};
   end

`ifdef MAC_SAT_EN
   localparam logic signed [SUM_W-1:0] MAX_S = {{(SUM_W-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
   localparam logic signed [SUM_W-1:0] MIN_S = ~MAX_S;

   // Clamp the sum into the signed result range and flag any clamp.
   always_comb begin
      if (sum_s > MAX_S) begin
         y   = {1'b0, {(ACC_W-1){1'b1}}};
         ovf = 1'b1;
      end else if (sum_s < MIN_S) begin
         y   = {1'b1, {(ACC_W-1){1'b0}}};
         ovf = 1'b1;
      end else begin
         y   = sum_s[ACC_W-1:0];
         ovf = 1'b0;
      end
   end
`else
   // Keep the low bits (two's-complement wrap); overflow is not reported.
   always_comb begin
      y   = sum_s[ACC_W-1:0];
      ovf = 1'b0;
   end
`endif

endmodule

// File: rtl/bp_mac_array.sv
// Multi-lane two-stage pipelined signed MAC with valid/ready on both sides.
// CHAIN mode adds the external t_in; ACCUM mode accumulates acc_len beats in
// the y_out register and presents one result per group.
// Build option MAC_SAT_EN selects saturating adds (see mac_lane_sat).
module bp_mac_array
   import mac_pkg::*;
#(
   parameter int LANES = 4,
   parameter int A_W   = 16,
   parameter int W_W   = 16,
   parameter int ACC_W = 24,
   parameter int LEN_W = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     mode,
   input  logic [LEN_W-1:0]         acc_len,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [LANES*A_W-1:0]     a_in,
   input  logic [LANES*W_W-1:0]     w_in,
   input  logic [LANES*ACC_W-1:0]   t_in,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [LANES*ACC_W-1:0]   y_out,
   output logic [LANES-1:0]         ovf
);

   localparam int              P_W     = A_W + W_W;
   localparam logic [LEN_W-1:0] LEN_ONE = {{(LEN_W-1){1'b0}}, 1'b1};

   logic adv_s;
   logic accept_s;

   grp_state_t       state_r, state_nxt_s;
   logic [LEN_W-1:0] cnt_r, cnt_nxt_s;
   logic [LEN_W-1:0] len_r, len_nxt_s;
   logic             grp_mode_r, grp_mode_nxt_s;
   logic [LEN_W-1:0] eff_len_s;
   logic             beat_mode_s, first_s, last_s;

   logic [P_W-1:0]          prod_s [LANES];
   logic                    s1_valid_r, s1_first_r, s1_last_r, s1_mode_r;
   logic signed [P_W-1:0]   p_r    [LANES];
   logic signed [ACC_W-1:0] t_r    [LANES];

   logic signed [ACC_W-1:0] addend_s [LANES];
   logic [LANES*ACC_W-1:0]  sum_vec_s;
   logic [LANES-1:0]        step_ovf_s;

   logic [LANES*ACC_W-1:0]  y_r;
   logic [LANES-1:0]        ovf_r;
   logic                    out_valid_r;

   assign adv_s     = !out_valid_r || out_ready;
   assign accept_s  = in_valid && adv_s;
   assign in_ready  = adv_s;
   assign out_valid = out_valid_r;
   assign y_out     = y_r;
   assign ovf       = ovf_r;

   // Group FSM register: state, beat counter and the group's latched mode/length.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= IDLE;
         cnt_r      <= {LEN_W{1'b0}};
         len_r      <= LEN_ONE;
         grp_mode_r <= MAC_MODE_CHAIN;
      end else begin
         state_r    <= state_nxt_s;
         cnt_r      <= cnt_nxt_s;
         len_r      <= len_nxt_s;
         grp_mode_r <= grp_mode_nxt_s;
      end
   end

   // Group FSM next state plus the first/last tag and effective mode of the current beat.
   always_comb begin
      state_nxt_s    = state_r;
      cnt_nxt_s      = cnt_r;
      len_nxt_s      = len_r;
      grp_mode_nxt_s = grp_mode_r;
      eff_len_s      = (acc_len == {LEN_W{1'b0}}) ? LEN_ONE : acc_len;
      beat_mode_s    = grp_mode_r;
      first_s        = 1'b0;
      last_s         = 1'b0;
      case (state_r)
         IDLE: begin
            beat_mode_s = mode;
            first_s     = 1'b1;
            last_s      = (mode == MAC_MODE_CHAIN) || (eff_len_s == LEN_ONE);
            if (accept_s) begin
               len_nxt_s      = eff_len_s;
               grp_mode_nxt_s = mode;
               if (last_s) begin
                  state_nxt_s = IDLE;
                  cnt_nxt_s   = {LEN_W{1'b0}};
               end else begin
                  state_nxt_s = ACC;
                  cnt_nxt_s   = LEN_ONE;
               end
            end else begin
               state_nxt_s = IDLE;
            end
         end
         ACC: begin
            last_s = (cnt_r == (len_r - LEN_ONE));
            if (accept_s) begin
               if (last_s) begin
                  state_nxt_s = IDLE;
                  cnt_nxt_s   = {LEN_W{1'b0}};
               end else begin
                  state_nxt_s = ACC;
                  cnt_nxt_s   = cnt_r + LEN_ONE;
               end
            end else begin
               state_nxt_s = ACC;
            end
         end
         default: begin
            state_nxt_s = IDLE;
            cnt_nxt_s   = {LEN_W{1'b0}};
         end
      endcase
   end

   // Per-lane signed products; operands are sign-extended so the low P_W bits are exact.
   always_comb begin
      for (int i = 0; i < LANES; i++) begin
         prod_s[i] = {{W_W{a_in[i*A_W+A_W-1]}}, a_in[i*A_W +: A_W]} *
                     {{A_W{w_in[i*W_W+W_W-1]}}, w_in[i*W_W +: W_W]};
      end
   end

   // Stage 1: capture products, addends and the beat's group tags when the pipe advances.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_r <= 1'b0;
         s1_first_r <= 1'b0;
         s1_last_r  <= 1'b0;
         s1_mode_r  <= MAC_MODE_CHAIN;
         for (int i = 0; i < LANES; i++) begin
            p_r[i] <= {P_W{1'b0}};
            t_r[i] <= {ACC_W{1'b0}};
         end
      end else if (adv_s) begin
         s1_valid_r <= in_valid;
         s1_first_r <= first_s;
         s1_last_r  <= last_s;
         s1_mode_r  <= beat_mode_s;
         for (int i = 0; i < LANES; i++) begin
            p_r[i] <= prod_s[i];
            t_r[i] <= t_in[i*ACC_W +: ACC_W];
         end
      end
   end

   // Addend select: t_in in CHAIN, zero on a group's first beat, else the running accumulator.
   always_comb begin
      for (int i = 0; i < LANES; i++) begin
         if (s1_mode_r == MAC_MODE_CHAIN) begin
            addend_s[i] = t_r[i];
         end else if (s1_first_r) begin
            addend_s[i] = {ACC_W{1'b0}};
         end else begin
            addend_s[i] = y_r[i*ACC_W +: ACC_W];
         end
      end
   end

   generate
      for (genvar g = 0; g < LANES; g++) begin : g_lane
         mac_lane_sat #(
            .A_W   (A_W),
            .W_W   (W_W),
            .ACC_W (ACC_W)
         ) u_lane (
            .p      (p_r[g]),
            .addend (addend_s[g]),
            .y      (sum_vec_s[g*ACC_W +: ACC_W]),
            .ovf    (step_ovf_s[g])
         );
      end
   endgenerate

   // Stage 2: write the sum into y_out; present it only for CHAIN beats or a group's last beat.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_r <= 1'b0;
         y_r         <= {(LANES*ACC_W){1'b0}};
         ovf_r       <= {LANES{1'b0}};
      end else if (adv_s) begin
         out_valid_r <= s1_valid_r && ((s1_mode_r == MAC_MODE_CHAIN) || s1_last_r);
         if (s1_valid_r) begin
            y_r   <= sum_vec_s;
            ovf_r <= ((s1_mode_r == MAC_MODE_ACCUM) && !s1_first_r) ? (ovf_r | step_ovf_s)
                                                                      : step_ovf_s;
         end
      end
   end

endmodule

// File: tb/tb_bp_mac_array.sv
// Self-checking bench for bp_mac_array: directed cases plus randomized traffic
// against a beat-level reference model. Honors MAC_SAT_EN like the design.
module tb_bp_mac_array;

   localparam int LANES = 4;
   localparam int A_W   = 16;
   localparam int W_W   = 16;
   localparam int ACC_W = 24;
   localparam int LEN_W = 8;
   localparam int YW    = LANES*ACC_W;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             mode = 1'b0;
   logic [LEN_W-1:0] acc_len = '0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [LANES*A_W-1:0]   a_in = '0;
   logic [LANES*W_W-1:0]   w_in = '0;
   logic [LANES*ACC_W-1:0] t_in = '0;
   logic             out_valid;
   logic             out_ready = 1'b1;
   logic [YW-1:0]    y_out;
   logic [LANES-1:0] ovf;

   bp_mac_array #(.LANES(LANES), .A_W(A_W), .W_W(W_W), .ACC_W(ACC_W), .LEN_W(LEN_W)) dut (
      .clk(clk), .rst_n(rst_n), .mode(mode), .acc_len(acc_len),
      .in_valid(in_valid), .in_ready(in_ready),
      .a_in(a_in), .w_in(w_in), .t_in(t_in),
      .out_valid(out_valid), .out_ready(out_ready),
      .y_out(y_out), .ovf(ovf)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%0h expected=%0h @%0t", tag, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      logic [YW-1:0]    y;
      logic [LANES-1:0] ov;
      int               cyc;
   } exp_t;

   exp_t   exp_q[$];
   bit     m_in_grp = 0;
   bit     m_mode = 0;
   int     m_len = 1;
   int     m_cnt = 0;
   longint m_acc [LANES];
   bit     m_ovf [LANES];
   int     cyc = 0;
   int     last_stall = 0;
   int     pops = 0;
   int     stalls = 0;
   bit     hold_valid = 0;
   logic [YW-1:0]    hold_y;
   logic [LANES-1:0] hold_ovf;
   bit     rand_bp = 0;

   // Reduce an exact sum to the ACC_W result range.
   function automatic void reduce(input longint s, output longint r, output bit ov);
      longint maxv, minv;
      maxv = (longint'(1) <<< (ACC_W-1)) - 1;
      minv = -(longint'(1) <<< (ACC_W-1));
`ifdef MAC_SAT_EN
      if (s > maxv) begin r = maxv; ov = 1; end
      else if (s < minv) begin r = minv; ov = 1; end
      else begin r = s; ov = 0; end
`else
      r  = (s <<< (64-ACC_W)) >>> (64-ACC_W);
      ov = (minv > maxv);
`endif
   endfunction

   task automatic model_beat();
      bit     first;
      longint p, add, r;
      bit     ov;
      exp_t   e;
      first = !m_in_grp;
      if (first) begin
         m_mode = mode;
         m_len  = (acc_len == 0) ? 1 : int'(acc_len);
         m_cnt  = 0;
      end
      for (int l = 0; l < LANES; l++) begin
         p = longint'($signed(a_in[l*A_W +: A_W])) * longint'($signed(w_in[l*W_W +: W_W]));
         if (m_mode == 1'b0) add = longint'($signed(t_in[l*ACC_W +: ACC_W]));
         else if (first)     add = 0;
         else                add = m_acc[l];
         reduce(p + add, r, ov);
         m_acc[l] = r;
         m_ovf[l] = (m_mode == 1'b0 || first) ? ov : (m_ovf[l] | ov);
      end
      m_cnt++;
      if (m_mode == 1'b0 || m_cnt == m_len) begin
         for (int l = 0; l < LANES; l++) begin
            e.y[l*ACC_W +: ACC_W] = m_acc[l][ACC_W-1:0];
            e.ov[l] = m_ovf[l];
         end
         e.cyc = cyc;
         exp_q.push_back(e);
         m_in_grp = 0;
      end else begin
         m_in_grp = 1;
      end
   endtask

   // Monitor: handshake rule, stall stability, result order/value/latency, model update.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         cyc++;
         if (!rst_n) begin
            m_in_grp = 0;
            exp_q.delete();
            hold_valid = 0;
            last_stall = cyc;
         end else begin
            check_eq("in_ready_rule", in_ready, !out_valid || out_ready);
            if (hold_valid) begin
               check_eq("hold_valid", out_valid, 1'b1);
               check_eq("hold_y", y_out, hold_y);
               check_eq("hold_ovf", ovf, hold_ovf);
            end
            if (out_valid && out_ready) begin
               check_eq("out_expected", exp_q.size() != 0, 1'b1);
               if (exp_q.size() != 0) begin
                  e = exp_q.pop_front();
                  check_eq("y_out", y_out, e.y);
                  check_eq("ovf", ovf, e.ov);
                  if (e.cyc > last_stall) check_eq("latency", cyc, e.cyc + 2);
                  pops++;
               end
            end
            if (out_valid && !out_ready) begin
               last_stall = cyc;
               stalls++;
            end
            hold_valid = out_valid && !out_ready;
            hold_y     = y_out;
            hold_ovf   = ovf;
            if (in_valid && in_ready) model_beat();
         end
      end
   end

   // Random downstream backpressure when enabled.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
      end
   end

   // ---------------- drivers ----------------
   task automatic send(input logic m, input logic [LEN_W-1:0] l, input logic [LANES*A_W-1:0] a,
                       input logic [LANES*W_W-1:0] w, input logic [LANES*ACC_W-1:0] t);
      bit took;
      took = 0;
      mode = m; acc_len = l; a_in = a; w_in = w; t_in = t; in_valid = 1'b1;
      for (int n = 0; n < 200 && !took; n++) begin
         @(negedge clk);
         took = in_ready;
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      check_eq("send_accept", took, 1'b1);
   endtask

   task automatic wait_out(input string tag);
      bit seen;
      seen = 0;
      for (int n = 0; n < 50 && !seen; n++) begin
         @(negedge clk);
         seen = out_valid;
      end
      check_eq(tag, seen, 1'b1);
   endtask

   task automatic drain();
      for (int n = 0; n < 100 && exp_q.size() != 0; n++) @(negedge clk);
      check_eq("drain_empty", exp_q.size(), 0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      int p0;
      logic [LANES*A_W-1:0]   ra;
      logic [LANES*W_W-1:0]   rw;
      logic [LANES*ACC_W-1:0] rt;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check_eq("rst_out_valid", out_valid, 1'b0);
      check_eq("rst_y", y_out, '0);
      check_eq("rst_ovf", ovf, '0);
      check_eq("rst_in_ready", in_ready, 1'b1);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // CHAIN 3 * -4 + 100 = 88, two cycles after acceptance
      send(1'b0, 8'd0, {LANES{16'd3}}, {LANES{16'hFFFC}}, {LANES{24'd100}});
      @(negedge clk);
      check_eq("chain_not_early", out_valid, 1'b0);
      @(negedge clk);
      check_eq("chain_valid", out_valid, 1'b1);
      check_eq("chain_y0", y_out[ACC_W-1:0], 24'd88);
      check_eq("chain_ovf", ovf, 4'b0000);
      drain();

      // CHAIN large product
      send(1'b0, 8'd0, {LANES{16'h7FFF}}, {LANES{16'h7FFF}}, {LANES{24'd0}});
      wait_out("sat_seen");
`ifdef MAC_SAT_EN
      check_eq("big_y0", y_out[ACC_W-1:0], 24'h7FFFFF);
      check_eq("big_ovf", ovf, 4'b1111);
`else
      check_eq("big_y0", y_out[ACC_W-1:0], 24'hFF0001);
      check_eq("big_ovf", ovf, 4'b0000);
`endif
      drain();

      // ACCUM, acc_len=4: 1,2,3,4 times 2 -> single result 20
      p0 = pops;
      for (int i = 1; i <= 4; i++)
         send(1'b1, 8'd4, {LANES{16'(i)}}, {LANES{16'd2}}, {LANES{24'd999}});
      wait_out("accum_seen");
      check_eq("accum_y0", y_out[ACC_W-1:0], 24'd20);
      drain();
      check_eq("accum_one_pulse", pops - p0, 1);

      // Backpressure: 5 CHAIN beats with out_ready low for 3 cycles mid-stream
      p0 = pops;
      stalls = 0;
      fork
         begin
            for (int i = 0; i < 5; i++)
               send(1'b0, 8'd0, {LANES{16'(i+1)}}, {LANES{16'd7}}, {LANES{24'(i*10)}});
         end
         begin
            repeat (3) @(posedge clk);
            #1 out_ready = 1'b0;
            repeat (3) @(posedge clk);
            #1 out_ready = 1'b1;
         end
      join
      drain();
      check_eq("bp_count", pops - p0, 5);
      check_eq("bp_stalled", stalls >= 3, 1'b1);

      // ACCUM with acc_len=0 behaves as length 1
      p0 = pops;
      for (int i = 0; i < 3; i++) begin
         ra = {$urandom, $urandom};
         rw = {$urandom, $urandom};
         send(1'b1, 8'd0, ra, rw, '0);
      end
      drain();
      check_eq("len0_count", pops - p0, 3);

      // Reset in the middle of a 4-beat group
      send(1'b1, 8'd4, {LANES{16'd5}}, {LANES{16'd5}}, '0);
      send(1'b1, 8'd4, {LANES{16'd5}}, {LANES{16'd5}}, '0);
      rst_n = 1'b0;
      #1;
      check_eq("mrst_out_valid", out_valid, 1'b0);
      check_eq("mrst_y", y_out, '0);
      check_eq("mrst_ovf", ovf, '0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      for (int i = 0; i < 4; i++)
         send(1'b1, 8'd4, {LANES{16'd1}}, {LANES{16'd1}}, '0);
      wait_out("post_rst_seen");
      check_eq("post_rst_y0", y_out[ACC_W-1:0], 24'd4);
      drain();

      // Randomized traffic with random backpressure and mid-group control changes
      rand_bp = 1;
      for (int n = 0; n < 300; n++) begin
         for (int l = 0; l < LANES; l++) begin
            case ($urandom_range(0, 7))
               0:       begin ra[l*A_W +: A_W] = 16'h8000; rw[l*W_W +: W_W] = 16'h8000; end
               1:       begin ra[l*A_W +: A_W] = 16'h7FFF; rw[l*W_W +: W_W] = 16'h8000; end
               default: begin ra[l*A_W +: A_W] = 16'($urandom); rw[l*W_W +: W_W] = 16'($urandom); end
            endcase
            rt[l*ACC_W +: ACC_W] = 24'($urandom);
         end
         send(1'($urandom_range(0, 1)), 8'($urandom_range(0, 5)), ra, rw, rt);
         if ($urandom_range(0, 4) == 0) begin
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
         end
      end
      // Finish any open ACCUM group so every accepted beat is accounted for
      while (m_in_grp) send(1'b1, 8'd1, '0, '0, '0);
      rand_bp = 0;
      @(posedge clk);
      #1 out_ready = 1'b1;
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Global watchdog so the run always ends.
   initial begin
      #2000000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
